// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider.
// Each channel divides clk by a runtime ratio and drives a registered tick
// (high while the channel count is 0) and a near-50% divided clock.
// dclk follows the selected channel and switches only on a period boundary.
module prog_clock_divider #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      div_we,
  input  logic [$clog2(NUM_CH)-1:0] div_ch,
  input  logic [CNT_W-1:0]          div_val,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         clk_out,
  output logic                      dclk,
  output logic [$clog2(NUM_CH)-1:0] sel_q
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] div_q    [NUM_CH];
  logic [CNT_W-1:0] pend_q   [NUM_CH];

  logic [CNT_W-1:0] pend_nxt [NUM_CH];
  logic [CNT_W-1:0] div_nxt  [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt  [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] tick_nxt;
  logic [NUM_CH-1:0] high_nxt;
  logic              sel_hit;

  // Per-channel next state: pending capture (with bypass into the wrap),
  // counter wrap, and the registered-output values for the next count.
  // An out-of-range div_ch or sel matches no channel and is thereby ignored.
  always_comb begin
    wrap     = '0;
    tick_nxt = '0;
    high_nxt = '0;
    sel_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pend_nxt[i] = pend_q[i];
      if (div_we && (div_ch == CH_W'(i))) begin
        pend_nxt[i] = (div_val == '0) ? CNT_W'(1) : div_val;
      end
      wrap[i]     = (count_q[i] == div_q[i] - CNT_W'(1));
      div_nxt[i]  = wrap[i] ? pend_nxt[i] : div_q[i];
      cnt_nxt[i]  = wrap[i] ? '0 : count_q[i] + CNT_W'(1);
      tick_nxt[i] = (cnt_nxt[i] == '0);
      // high while next count < ceil(div/2); one extra bit avoids overflow at div = 2^CNT_W-1
      high_nxt[i] = ({1'b0, cnt_nxt[i]} <
                     (({1'b0, div_nxt[i]} + (CNT_W + 1)'(1)) >> 1));
      if ((sel == CH_W'(i)) && wrap[i]) begin
        sel_hit = 1'b1;
      end
    end
  end

  // Channel state, registered outputs and active-select register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
        div_q[i]   <= CNT_W'(RST_DIV);
        pend_q[i]  <= CNT_W'(RST_DIV);
      end
      tick    <= '1;
      clk_out <= '1;
      sel_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= pend_nxt[i];
        if (en) begin
          count_q[i] <= cnt_nxt[i];
          div_q[i]   <= div_nxt[i];
          tick[i]    <= tick_nxt[i];
          clk_out[i] <= high_nxt[i];
        end
      end
      if (en && (sel != sel_q) && sel_hit) begin
        sel_q <= sel;
      end
    end
  end

  // sel_q and clk_out change on the same edge, so the mux output is glitch-free.
  assign dclk = clk_out[sel_q];

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a behavioural model pushes the
// expected post-edge outputs when stimulus is applied; they are popped and
// compared just after the edge.
module tb_prog_clock_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       div_we;
  logic [1:0] div_ch;
  logic [7:0] div_val;
  logic [1:0] sel;
  logic [3:0] tick;
  logic [3:0] clk_out;
  logic       dclk;
  logic [1:0] sel_q;

  prog_clock_divider #(
    .NUM_CH (4),
    .CNT_W  (8),
    .RST_DIV(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .div_we (div_we),
    .div_ch (div_ch),
    .div_val(div_val),
    .sel    (sel),
    .tick   (tick),
    .clk_out(clk_out),
    .dclk   (dclk),
    .sel_q  (sel_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tick;
    logic [3:0] clk_out;
    logic [1:0] sel_q;
    logic       dclk;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int m_cnt  [4];
  int m_div  [4];
  int m_pend [4];
  int m_selq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    exp_t e;
    bit   w[4];
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_div[i] = 2; m_pend[i] = 2;
      end
      m_selq = 0;
    end else begin
      for (int i = 0; i < 4; i++) w[i] = (m_cnt[i] + 1 == m_div[i]);
      if (div_we) m_pend[div_ch] = (div_val == 0) ? 1 : int'(div_val);
      if (en) begin
        if ((int'(sel) != m_selq) && w[sel]) m_selq = int'(sel);
        for (int i = 0; i < 4; i++) begin
          if (w[i]) begin
            m_cnt[i] = 0;
            m_div[i] = m_pend[i];
          end else begin
            m_cnt[i]++;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.tick[i]    = (m_cnt[i] == 0);
      e.clk_out[i] = (2 * m_cnt[i] < m_div[i]);
    end
    e.sel_q = 2'(m_selq);
    e.dclk  = e.clk_out[m_selq];
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_val("tick",    32'(tick),    32'(e.tick));
    check_val("clk_out", 32'(clk_out), 32'(e.clk_out));
    check_val("sel_q",   32'(sel_q),   32'(e.sel_q));
    check_val("dclk",    32'(dclk),    32'(e.dclk));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] val);
    div_we  = 1'b1;
    div_ch  = ch;
    div_val = val;
    step();
    div_we  = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    bit         seen;
    rst_n = 1'b0; en = 1'b0; div_we = 1'b0; div_ch = '0; div_val = '0; sel = '0;

    // reset state
    run(2);
    check_val("rst_tick",  32'(tick),    32'hF);
    check_val("rst_clk",   32'(clk_out), 32'hF);
    check_val("rst_selq",  32'(sel_q),   32'h0);
    check_val("rst_dclk",  32'(dclk),    32'h1);

    // default /2 everywhere, then ch1 -> /3 written at count 0
    rst_n = 1'b1; en = 1'b1;
    wr(2'd1, 8'd3);
    run(12);

    // ratio 0 is treated as 1: ch2 constantly high
    wr(2'd2, 8'd0);
    run(3);
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("ch2_div1", 32'({tick[2], clk_out[2]}), 32'h3);
    end

    // ch3 -> /8, then request dclk from ch3; switch only at ch3 wrap
    wr(2'd3, 8'd8);
    run(10);
    sel  = 2'd3;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step();
      if (sel_q == 2'd3) seen = 1'b1;
    end
    check_val("sel_switch_seen", 32'(seen), 32'h1);
    if (seen) begin
      pat = 8'b1111_0000;
      check_val("dclk_win", 32'(dclk), 32'(pat[7]));
      for (int k = 1; k < 8; k++) begin
        step();
        check_val("dclk_win", 32'(dclk), 32'(pat[7-k]));
      end
    end
    sel = 2'd0;
    run(10);

    // freeze with en=0 while a ch0 ratio write is captured
    run(1);
    en = 1'b0;
    wr(2'd0, 8'd5);
    run(4);
    en = 1'b1;
    run(20);

    // mid-period reset with ch1 at /6
    wr(2'd1, 8'd6);
    run(9);
    rst_n = 1'b0;
    step();
    check_val("mrst_tick", 32'(tick),    32'hF);
    check_val("mrst_clk",  32'(clk_out), 32'hF);
    check_val("mrst_selq", 32'(sel_q),   32'h0);
    rst_n = 1'b1;
    run(8);

    // random mix of enables, writes and select requests
    for (int k = 0; k < 300; k++) begin
      en      = ($urandom % 8) != 0;
      div_we  = ($urandom % 4) == 0;
      div_ch  = 2'($urandom % 4);
      div_val = 8'($urandom_range(0, 9));
      if ($urandom % 10 == 0) sel = 2'($urandom % 4);
      step();
    end
    div_we = 1'b0;

    check_val("queue_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Multi-channel programmable clock divider. Each of NUM_CH channels divides clk by a runtime-programmable ratio D (1..2^CNT_W-1).
- Each channel produces a registered one-cycle-per-period tick and a near-50% duty divided clock.
- Provides a select output dclk whose channel switch happens only at a period boundary.
- Sits between the board clock and the lab display/scan logic; replaces the fixed /2 /3 /4 /8 divider generation.

Parameters:
NUM_CH, 4, number of divider channels (>=2)
CNT_W, 8, width of divide ratio and per-channel counter
RST_DIV, 2, divide ratio loaded into every channel at reset (1..2^CNT_W-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
en  in  1  count enable; 0 freezes all counters and outputs
div_we  in  1  write strobe for a channel's divide ratio
div_ch  in  $clog2(NUM_CH)  channel addressed by div_we
div_val  in  CNT_W  new divide ratio; 0 is treated as 1
sel  in  $clog2(NUM_CH)  requested channel for dclk
tick  out  NUM_CH  per-channel registered pulse, high while that channel's count==0
clk_out  out  NUM_CH  per-channel divided clock, registered
dclk  out  1  clk_out of the currently active selected channel
sel_q  out  $clog2(NUM_CH)  currently active dclk channel

Behaviour:
- Reset (rst_n=0 at posedge clk) sets, per channel:
  - count=0, active div=RST_DIV, pending div=RST_DIV, tick=1, clk_out=1.
  - sel_q=0, so dclk=1.
- Reset has priority over en and div_we; mid-period reset discards the partial period.
- Per channel, on each posedge with en=1:
  - count <= (count==div-1) ? 0 : count+1 (wrap).
  - tick <= (next count==0).
  - clk_out <= (next count < ceil(div/2)).
  - Result: outputs are aligned to count with one register stage; there is no combinational path from count to outputs.
  - Odd div: high for (div+1)/2 cycles, low for (div-1)/2 (e.g. div=3: 2 high, 1 low).
  - div=1: count stays 0, tick=1 and clk_out=1 constantly.
- en=0: count, tick, clk_out and sel_q hold; div writes are still captured into the pending register.
- Ratio update:
  - div_we=1 writes max(div_val,1) to pending[div_ch].
  - div_ch >= NUM_CH: write ignored.
  - Active div loads from pending only at a wrap (count==div-1 with en=1), so no truncated or stretched periods occur.
  - A write in the same cycle as that channel's wrap takes effect at that wrap (bypass).
  - Two writes before a wrap: the last one wins.
  - Writes do not alter count.
- Select switching:
  - sel_q <= sel on a posedge where en=1, sel!=sel_q, and channel sel is at wrap (count==div-1, or div==1).
  - Consequently the new channel starts a fresh period (clk_out=1, tick=1) in the same cycle sel_q changes.
  - Requests to an out-of-range sel are ignored.
  - sel may change again before a switch; the pending target is whatever sel is at the switching edge.
- dclk = clk_out[sel_q], a combinational mux of registered signals; it is glitch-free because sel_q and clk_out update on the same edge.
- All channels run independently; simultaneous wraps, writes and switch on different channels need no arbitration.

Test Plan:
- Reset, en=1, no writes: every channel repeats tick=1,0 and clk_out=1,0 (period 2). dclk equals clk_out[0]. All tick bits assert on the first cycle after reset release.
- Write ch1=3 at count=0: the current /2 period completes. Then tick[1] pattern 1,0,0 repeating and clk_out[1] pattern 1,1,0 repeating.
- Write ch2=0: treated as 1, so tick[2]=clk_out[2]=1 constantly. A write to div_ch=NUM_CH (if representable) changes no channel.
- ch3 div=8, sel changed from 0 to 3 at ch3 count=2: sel_q stays 0 until ch3 count==7. Next cycle sel_q=3 and dclk=1 for 4 cycles, then 0 for 4. No dclk pulse shorter than 1 cycle.
- en=0 for 5 cycles mid-period with a div_we to ch0=5: outputs frozen. After en=1, the current period finishes, then period becomes 5 (clk_out 3 high, 2 low).
- rst_n=0 for 1 cycle mid-period with ch1 div=6: all counts=0, tick=all-ones, clk_out=all-ones, sel_q=0, div reverts to RST_DIV.
